// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit layout, default buffer sizing and the
// one-hot turn codes exchanged between input buffers and route logic.
package noc_pkg;

    localparam int FLIT_W    = 8;
    localparam int BUF_DEPTH = 4;
    localparam int NUM_PORTS = 5;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } flit_t;

    localparam logic [NUM_PORTS-1:0] TURN_N = 5'b00001;
    localparam logic [NUM_PORTS-1:0] TURN_S = 5'b00010;
    localparam logic [NUM_PORTS-1:0] TURN_E = 5'b00100;
    localparam logic [NUM_PORTS-1:0] TURN_W = 5'b01000;
    localparam logic [NUM_PORTS-1:0] TURN_L = 5'b10000;

    function automatic flit_t flit_unpack(input logic [FLIT_W-1:0] raw);
        return flit_t'(raw);
    endfunction

endpackage

// File: rtl/noc_fifo_mem.sv
// Flit storage for one input buffer: single write port, asynchronous read.
// Contents are deliberately not reset; the owner gates stale data on empty.
module noc_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 8,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [FLIT_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [FLIT_W-1:0] rd_data_o
);

    logic [FLIT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/input_buffer.sv
// Router input buffer: credit-flow-controlled FIFO between an upstream link
// and the route logic. Each pop returns one credit on the following cycle.
module input_buffer #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::BUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FLIT_W-1:0]      link_data_i,
    input  logic                   link_valid_i,
    output logic                   credit_o,
    output logic [FLIT_W-1:0]      head_data_o,
    output logic                   head_valid_o,
    input  logic                   remove_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   overflow_o
);

    import noc_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              credit_q, credit_d;
    logic              overflow_q, overflow_d;
    logic              empty, full;
    logic              do_push, do_pop;
    logic [FLIT_W-1:0] mem_rdata;

    // A full buffer still accepts a flit when a pop frees a slot that cycle.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == FULL_CNT);
        do_pop     = remove_i && !empty;
        do_push    = link_valid_i && (!full || do_pop);

        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d    = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end

        credit_d   = do_pop;
        overflow_d = overflow_q | (link_valid_i & ~do_push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    noc_fifo_mem #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W),
        .AW     (AW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (do_push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (link_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rdata)
    );

    // Storage is never cleared, so the head is masked whenever the FIFO is empty.
    assign head_valid_o = !empty;
    assign head_data_o  = empty ? '0 : mem_rdata;
    assign count_o      = count_q;
    assign full_o       = full;
    assign credit_o     = credit_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: a queue-based reference model checked
// every falling edge, plus hand-computed literal checks on key scenarios.
module tb_input_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] link_data_i = 8'h00;
    logic       link_valid_i = 1'b0;
    logic       remove_i = 1'b0;
    logic       credit_o;
    logic [7:0] head_data_o;
    logic       head_valid_o;
    logic [2:0] count_o;
    logic       full_o;
    logic       overflow_o;

    int total = 0;
    int bad = 0;
    int credits_seen = 0;

    logic [7:0] mq[$];
    logic       m_credit = 1'b0;
    logic       m_ovf = 1'b0;

    always #5 clk = ~clk;

    input_buffer #(.FLIT_W(8), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .link_data_i  (link_data_i),
        .link_valid_i (link_valid_i),
        .credit_o     (credit_o),
        .head_data_o  (head_data_o),
        .head_valid_o (head_valid_o),
        .remove_i     (remove_i),
        .count_o      (count_o),
        .full_o       (full_o),
        .overflow_o   (overflow_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated by the FIFO rules.
    always @(posedge clk or negedge rst_n) begin
        bit m_pop, m_push;
        if (!rst_n) begin
            mq.delete();
            m_credit = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_pop  = remove_i && (mq.size() > 0);
            m_push = link_valid_i && ((mq.size() < DEPTH) || m_pop);
            if (link_valid_i && !m_push) m_ovf = 1'b1;
            m_credit = m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(link_data_i);
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_head;
        exp_head = (mq.size() > 0) ? mq[0] : 8'h00;
        chk("m_count",    32'(count_o),      32'(mq.size()));
        chk("m_full",     32'(full_o),       32'(mq.size() == DEPTH));
        chk("m_hvalid",   32'(head_valid_o), 32'(mq.size() > 0));
        chk("m_hdata",    32'(head_data_o),  32'(exp_head));
        chk("m_credit",   32'(credit_o),     32'(m_credit));
        chk("m_overflow", 32'(overflow_o),   32'(m_ovf));
        if (credit_o) credits_seen++;
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        link_valid_i = v;
        link_data_i  = d;
        remove_i     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        link_valid_i = 1'b0;
        remove_i     = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fill4();
        step(1'b1, 8'h21, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h43, 1'b0);
        step(1'b1, 8'h54, 1'b0);
        link_valid_i = 1'b0;
    endtask

    initial begin
        logic [7:0] ord [4];
        int c0;
        ord[0] = 8'h21; ord[1] = 8'h32; ord[2] = 8'h43; ord[3] = 8'h54;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_count",  32'(count_o),      32'd0);
        chk("rst_hvalid", 32'(head_valid_o), 32'd0);
        chk("rst_credit", 32'(credit_o),     32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fill and drain, with no-bypass check on the first push
        link_valid_i = 1'b1;
        link_data_i  = 8'h21;
        #1 chk("no_bypass", 32'(head_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk("first_head", 32'(head_data_o), 32'h21);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h43, 1'b0);
        step(1'b1, 8'h54, 1'b0);
        link_valid_i = 1'b0;
        chk("fill_full",  32'(full_o),  32'd1);
        chk("fill_count", 32'(count_o), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 32'(head_data_o), 32'(ord[i]));
            step(1'b0, 8'h00, 1'b1);
            chk("drain_credit", 32'(credit_o), 32'd1);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("drain_credit_end", 32'(credit_o), 32'd0);
        chk("drain_count",      32'(count_o),  32'd0);

        // pop while empty
        step(1'b0, 8'h00, 1'b1);
        chk("empty_pop_credit", 32'(credit_o),    32'd0);
        chk("empty_pop_count",  32'(count_o),     32'd0);
        chk("empty_pop_head",   32'(head_data_o), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("empty_pop_credit2", 32'(credit_o), 32'd0);

        // overflow
        fill4();
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_flag",  32'(overflow_o),  32'd1);
        chk("ovf_count", 32'(count_o),     32'd4);
        chk("ovf_head",  32'(head_data_o), 32'h21);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(overflow_o), 32'd0);

        // push and pop together at full
        fill4();
        step(1'b1, 8'h77, 1'b1);
        chk("sim_count", 32'(count_o),     32'd4);
        chk("sim_ovf",   32'(overflow_o),  32'd0);
        chk("sim_head",  32'(head_data_o), 32'h32);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("sim_77", 32'(head_data_o), 32'h77);
        step(1'b0, 8'h00, 1'b1);
        chk("sim_empty", 32'(count_o), 32'd0);
        step(1'b0, 8'h00, 1'b0);

        // wrap: ten push/pop pairs from a fresh reset
        do_reset();
        c0 = credits_seen;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
            chk("wrap_head", 32'(head_data_o), 32'(8'h10 + i));
            step(1'b0, 8'h00, 1'b1);
        end
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("wrap_credits", 32'(credits_seen - c0), 32'd10);

        // async reset with flits stored and a credit pending
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        step(1'b1, 8'hA3, 1'b0);
        link_valid_i = 1'b0;
        remove_i     = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_credit", 32'(credit_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_count",  32'(count_o),      32'd0);
        chk("mid_rst_hvalid", 32'(head_valid_o), 32'd0);
        chk("mid_rst_hdata",  32'(head_data_o),  32'd0);
        chk("mid_rst_credit", 32'(credit_o),     32'd0);
        chk("mid_rst_full",   32'(full_o),       32'd0);
        remove_i = 1'b0;
        c0 = credits_seen;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step(1'b0, 8'h00, 1'b0);
        chk("post_rst_credits", 32'(credits_seen - c0), 32'd0);
        chk("post_rst_count",   32'(count_o),           32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 SHALL have parameter FLIT_W, default 8, flit width: bits [7:4] are destination X, bits [3:0] are destination Y.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port link_data_i  input  FLIT_W  flit arriving from the upstream router link.
REQ-006 SHALL have port link_valid_i  input  1  link_data_i holds a flit this cycle.
REQ-007 SHALL have port credit_o  output  1  one-cycle pulse returning one buffer credit upstream.
REQ-008 SHALL have port head_data_o  output  FLIT_W  oldest stored flit, driven to route logic X_data_i.
REQ-009 SHALL have port head_valid_o  output  1  FIFO non-empty, driven to route logic X_valid_i.
REQ-010 SHALL have port remove_i  input  1  pop request from route logic X_port_remove.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port full_o  output  1  occupancy equals DEPTH.
REQ-013 SHALL have port overflow_o  output  1  sticky flag: a flit arrived while full and was dropped.

Function
REQ-014 Push: the block SHALL write link_data_i at wr_ptr when link_valid_i=1 and (not full or pop in the same cycle); wr_ptr increments modulo DEPTH.
REQ-015 Pop: the block SHALL pop when remove_i=1 and head_valid_o=1; rd_ptr increments modulo DEPTH. remove_i while empty SHALL be ignored, with no credit and no state change.
REQ-016 count_o SHALL be +1 on push only, -1 on pop only, and unchanged on push and pop together, including at full (accept) and at empty (no pop).
REQ-017 head_data_o/head_valid_o SHALL be combinational from storage[rd_ptr] and count; head_data_o SHALL be 0 when empty.
REQ-018 Latency: a flit pushed in cycle N SHALL appear on head_valid_o in cycle N+1 at the earliest; there SHALL be no bypass.
REQ-019 credit_o SHALL be registered and SHALL pulse exactly one cycle in cycle N+1 for each pop in cycle N; consecutive pops SHALL give consecutive pulses.
REQ-020 Credit contract: upstream starts with DEPTH credits after reset; each pop returns exactly one; credits outstanding plus count_o SHALL equal DEPTH at all times absent overflow.
REQ-021 Push while full with no simultaneous pop SHALL drop the flit, leave pointers and count unchanged, and set overflow_o (cleared only by reset).
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 without losing FIFO order.
REQ-023 head_data_o SHALL be stable while head_valid_o=1 and remove_i=0, regardless of pushes.

Reset
REQ-024 rst_n low SHALL asynchronously force wr_ptr=0, rd_ptr=0, count_o=0, full_o=0, head_valid_o=0, head_data_o=0, credit_o=0, overflow_o=0.
REQ-025 Reset mid-operation SHALL discard all stored flits and any pending credit pulse; no credit_o SHALL be emitted for discarded flits.
REQ-026 Storage array contents need not be reset; output gating per REQ-017 SHALL hide stale data.

Structure
REQ-027 Package noc_pkg SHALL hold FLIT_W, BUF_DEPTH, the flit_t packed struct (x[3:0], y[3:0]) and one-hot TURN_N/S/E/W/L constants shared with the route logic.
REQ-028 Storage SHALL be one sub-module noc_fifo_mem (DEPTH x FLIT_W, one write port, one async read port); pointers, count, credit and overflow logic SHALL stay in input_buffer.
REQ-029 Five instances SHALL feed the N/S/E/W/L inputs of the route logic.

Verification
REQ-030 Fill and drain: push 8'h21, 8'h32, 8'h43, 8'h54 -> full_o=1, count_o=4; four pops -> head order 21,32,43,54, four credit_o pulses, each one cycle after its pop.
REQ-031 Overflow: with full, push 8'hAA without pop -> dropped, overflow_o=1 and sticky, count_o=4, head_data_o unchanged.
REQ-032 Simultaneous at full: push 8'h77 with pop -> count_o stays 4, 8'h77 emerges after three further pops, overflow_o=0.
REQ-033 Empty pop: remove_i=1 with count_o=0 -> no credit_o, count_o=0, head_data_o=0.
REQ-034 Wrap: 10 push/pop pairs of 8'h10..8'h19 -> order preserved across two pointer wraps; credit total 10.
REQ-035 Reset mid-stream: 3 flits stored and a pop in progress, then rst_n low asynchronously -> all outputs 0 immediately, no credit pulse after release.
